// File: rtl/stopwatch_pkg.sv
// -----------------------------------------------------------------------------
// stopwatch_pkg
// Shared definitions for the four-digit BCD stopwatch:
//   DIGIT_W / DIGIT_MAX / NUM_DIGITS - BCD digit geometry
//   sw_state_t                       - run/stop state of the control FSM
//   bcd_inc()                        - one BCD digit stage of the ripple chain
// -----------------------------------------------------------------------------
package stopwatch_pkg;

  localparam int                 DIGIT_W    = 4;
  localparam logic [DIGIT_W-1:0] DIGIT_MAX  = 4'd9;
  localparam int                 NUM_DIGITS = 4;

  typedef enum logic {
    STOP = 1'b0,
    RUN  = 1'b1
  } sw_state_t;

  // One BCD stage: returns {carry_out, next_digit}. With no carry in the
  // digit is passed through untouched; a 9 with carry in rolls to 0 and
  // passes the carry on.
  function automatic logic [DIGIT_W:0] bcd_inc(input logic [DIGIT_W-1:0] d,
                                               input logic               cin);
    logic [DIGIT_W:0] r;
    if (!cin) begin
      r = {1'b0, d};
    end else if (d == DIGIT_MAX) begin
      r = {1'b1, {DIGIT_W{1'b0}}};
    end else begin
      r = {1'b0, d + 1'b1};
    end
    return r;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Conditions one raw push-button: 2-FF synchroniser, stability counter and a
// rising-edge detector on the debounced level.
// Ports:
//   clk      in  system clock
//   rst      in  asynchronous active-high reset (level 0, counter 0)
//   btn_raw  in  raw button, asynchronous to clk
//   press    out one-cycle pulse when the debounced level rises
// -----------------------------------------------------------------------------
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press
);

  localparam int              CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             level_dly_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      sync1_q     <= btn_raw;
      sync2_q     <= sync1_q;
      level_q     <= level_d;
      level_dly_q <= level_q;
      cnt_q       <= cnt_d;
    end
  end

  // The counter measures how long the synchronised input has disagreed with
  // the accepted level; any agreement restarts the measurement.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d = ~level_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Rising edge only: releases never generate a pulse.
  assign press = level_q & ~level_dly_q;

endmodule

// File: rtl/bcd_stopwatch4.sv
// -----------------------------------------------------------------------------
// bcd_stopwatch4
// Four-digit BCD stopwatch producing the D3..D0 digits for a multiplexed
// display scanner.
// Ports:
//   clk        in  system clock
//   rst        in  asynchronous active-high reset
//   btn_start  in  raw start/stop button (toggles STOP/RUN)
//   btn_clr    in  raw clear button (STOP, digits and prescaler to zero)
//   D0..D3     out BCD digits, units..thousands, registered
//   running    out 1 while in RUN
//   ovf        out one-cycle pulse on the 9999 -> 0000 wrap
// -----------------------------------------------------------------------------
module bcd_stopwatch4
  import stopwatch_pkg::*;
#(
  parameter int CLK_DIV         = 50_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_start,
  input  logic               btn_clr,
  output logic [DIGIT_W-1:0] D0,
  output logic [DIGIT_W-1:0] D1,
  output logic [DIGIT_W-1:0] D2,
  output logic [DIGIT_W-1:0] D3,
  output logic               running,
  output logic               ovf
);

  localparam int               PRE_W    = $clog2(CLK_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);

  logic start_pulse, clr_pulse;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_start (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_start),
    .press   (start_pulse)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_clr (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_clr),
    .press   (clr_pulse)
  );

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  sw_state_t state_q, state_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= STOP;
    else     state_q <= state_d;
  end

  // Clear dominates a simultaneous start/stop press.
  always_comb begin
    state_d = state_q;
    if (clr_pulse) begin
      state_d = STOP;
    end else if (start_pulse) begin
      state_d = (state_q == RUN) ? STOP : RUN;
    end
  end

  always_comb begin
    running = (state_q == RUN);
  end

  // ---------------------------------------------------------------------------
  // Prescaler and BCD chain
  // ---------------------------------------------------------------------------
  logic [PRE_W-1:0]                        presc_q, presc_d;
  logic [NUM_DIGITS-1:0][DIGIT_W-1:0]      digits_q, digits_d;
  logic                                    ovf_q, ovf_d;
  logic                                    tick;
  logic                                    carry;

  // The prescaler only advances in RUN, so stopping freezes the sub-tick
  // phase and a resume picks up where it left off.
  assign tick = (state_q == RUN) && (presc_q == PRE_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q  <= '0;
      digits_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      digits_q <= digits_d;
      ovf_q    <= ovf_d;
    end
  end

  // A tick coinciding with a stop press is still counted (the FSM stops on
  // the same edge); a tick coinciding with clear is discarded.
  always_comb begin
    presc_d  = presc_q;
    digits_d = digits_q;
    ovf_d    = 1'b0;
    carry    = 1'b0;
    if (clr_pulse) begin
      presc_d  = '0;
      digits_d = '0;
    end else if (state_q == RUN) begin
      if (tick) begin
        presc_d = '0;
        carry   = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
          {carry, digits_d[i]} = bcd_inc(digits_q[i], carry);
        end
        // Carry out of the thousands digit is exactly the 9999 -> 0000 wrap.
        ovf_d = carry;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  assign D0  = digits_q[0];
  assign D1  = digits_q[1];
  assign D2  = digits_q[2];
  assign D3  = digits_q[3];
  assign ovf = ovf_q;

endmodule

// File: tb/tb_bcd_stopwatch4.sv
// -----------------------------------------------------------------------------
// tb_bcd_stopwatch4
// Directed bench for bcd_stopwatch4 (CLK_DIV=4, DEBOUNCE_CYCLES=3).
// A behavioural model tracks the count as a plain integer and the buttons as
// sample histories; a compare process checks every output on each falling
// edge, and the directed sequence pins the model with literal expectations.
// -----------------------------------------------------------------------------
module tb_bcd_stopwatch4;

  localparam int CD = 4;
  localparam int DC = 3;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_start = 1'b0;
  logic       btn_clr = 1'b0;
  logic [3:0] D0, D1, D2, D3;
  logic       running, ovf;

  always #5 clk = ~clk;

  bcd_stopwatch4 #(.CLK_DIV(CD), .DEBOUNCE_CYCLES(DC)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_start (btn_start),
    .btn_clr   (btn_clr),
    .D0        (D0),
    .D1        (D1),
    .D2        (D2),
    .D3        (D3),
    .running   (running),
    .ovf       (ovf)
  );

  logic [15:0] dut_digits;
  assign dut_digits = {D3, D2, D1, D0};

  int compared   = 0;
  int mismatched = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  int          m_cnt   = 0;     // displayed value 0..9999
  int          m_presc = 0;
  bit          m_run   = 0;
  bit          m_ovf   = 0;
  int          m_n     = 0;     // edges since reset
  logic [15:0] hist_s  = '0;    // bit i = raw sample i edges ago
  logic [15:0] hist_c  = '0;
  bit          lvl_s = 0, lvlp_s = 0, lvl_c = 0, lvlp_c = 0;

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    r = {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    return r;
  endfunction

  // The level flips once the input seen two edges late has differed from the
  // level for DC consecutive edges since reset.
  function automatic bit deb_flip(input logic [15:0] hist, input int n, input bit level);
    bit o;
    if (n < DC) return 1'b0;
    for (int i = 0; i < DC; i++) begin
      o = (n - i - 2 >= 1) ? hist[i+2] : 1'b0;
      if (o == level) return 1'b0;
    end
    return 1'b1;
  endfunction

  always @(posedge clk or posedge rst) begin
    bit press_s, press_c, tick;
    if (rst) begin
      m_cnt = 0; m_presc = 0; m_run = 0; m_ovf = 0; m_n = 0;
      hist_s = '0; hist_c = '0;
      lvl_s = 0; lvlp_s = 0; lvl_c = 0; lvlp_c = 0;
    end else begin
      m_n++;
      hist_s  = {hist_s[14:0], btn_start};
      hist_c  = {hist_c[14:0], btn_clr};
      press_s = lvl_s && !lvlp_s;
      press_c = lvl_c && !lvlp_c;
      lvlp_s  = lvl_s;
      lvlp_c  = lvl_c;
      if (deb_flip(hist_s, m_n, lvl_s)) lvl_s = !lvl_s;
      if (deb_flip(hist_c, m_n, lvl_c)) lvl_c = !lvl_c;

      tick  = m_run && (m_presc == CD - 1);
      m_ovf = 0;
      if (press_c) begin
        m_cnt = 0; m_presc = 0; m_run = 0;
      end else begin
        if (m_run) begin
          if (tick) begin
            m_presc = 0;
            m_ovf   = (m_cnt == 9999);
            m_cnt   = (m_cnt + 1) % 10000;
          end else begin
            m_presc++;
          end
        end
        if (press_s) m_run = !m_run;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Compare process
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (!rst) begin
      chk("cyc_digits",  32'(dut_digits), 32'(to_bcd(m_cnt)));
      chk("cyc_running", 32'(running),    32'(m_run));
      chk("cyc_ovf",     32'(ovf),        32'(m_ovf));
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
  endtask

  // Press start, wait for it to take effect (edge 6 after the raw rise).
  task automatic start_from_reset();
    btn_start = 1'b1;
    cyc(5);
    btn_start = 1'b0;
    cyc(1);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    // 1. Reset
    cyc(3);
    rst = 1'b0;
    chk("rst_digits",  32'(dut_digits), 32'h0000);
    chk("rst_running", 32'(running),    32'd0);
    chk("rst_ovf",     32'(ovf),        32'd0);
    cyc(20);
    chk("idle_digits",  32'(dut_digits), 32'h0000);
    chk("idle_running", 32'(running),    32'd0);

    // 2. Start and count
    btn_start = 1'b1;
    cyc(5);
    chk("start_edge5", 32'(running), 32'd0);
    cyc(1);
    chk("start_edge6", 32'(running), 32'd1);
    cyc(4);
    btn_start = 1'b0;
    cyc(44);
    chk("count_48", 32'(dut_digits), 32'h0012);

    // 3. Bounce rejection
    do_reset();
    btn_start = 1'b1; cyc(2);
    btn_start = 1'b0; cyc(2);
    btn_start = 1'b1; cyc(2);
    btn_start = 1'b0; cyc(8);
    chk("bounce_run", 32'(running), 32'd0);
    start_from_reset();
    chk("hold5_run", 32'(running), 32'd1);

    // 4. Pause/resume: stop lands with the prescaler two into its period
    cyc(8);
    btn_start = 1'b1; cyc(4);
    btn_start = 1'b0; cyc(2);
    chk("pause_run",    32'(running),    32'd0);
    chk("pause_digits", 32'(dut_digits), 32'h0003);
    cyc(20);
    chk("frozen_digits", 32'(dut_digits), 32'h0003);
    btn_start = 1'b1; cyc(4);
    btn_start = 1'b0; cyc(2);
    chk("resume_run", 32'(running),    32'd1);
    cyc(1);
    chk("resume_+1",  32'(dut_digits), 32'h0003);
    cyc(1);
    chk("resume_+2",  32'(dut_digits), 32'h0004);

    // 5. Wrap
    do_reset();
    start_from_reset();
    cyc(39999);
    chk("pre_wrap_digits", 32'(dut_digits), 32'h9999);
    chk("pre_wrap_ovf",    32'(ovf),        32'd0);
    cyc(1);
    chk("wrap_digits", 32'(dut_digits), 32'h0000);
    chk("wrap_ovf",    32'(ovf),        32'd1);
    cyc(1);
    chk("post_wrap_ovf", 32'(ovf), 32'd0);
    cyc(3);
    chk("post_wrap_digits", 32'(dut_digits), 32'h0001);
    chk("post_wrap_run",    32'(running),    32'd1);

    // 6a. Clear and start pulses coincide (also on a tick edge)
    do_reset();
    start_from_reset();
    cyc(10);
    chk("pre_clr_digits", 32'(dut_digits), 32'h0002);
    btn_start = 1'b1; btn_clr = 1'b1;
    cyc(4);
    btn_start = 1'b0; btn_clr = 1'b0;
    cyc(1);
    chk("clr_eve_digits", 32'(dut_digits), 32'h0003);
    cyc(1);
    chk("clr_run",    32'(running),    32'd0);
    chk("clr_digits", 32'(dut_digits), 32'h0000);
    chk("clr_ovf",    32'(ovf),        32'd0);

    // 6b. Reset mid-count, button held across reset
    do_reset();
    start_from_reset();
    cyc(12);
    chk("mid_digits", 32'(dut_digits), 32'h0003);
    #2;
    btn_start = 1'b1;
    rst = 1'b1;
    #1;
    chk("async_digits", 32'(dut_digits), 32'h0000);
    chk("async_run",    32'(running),    32'd0);
    chk("async_ovf",    32'(ovf),        32'd0);
    @(negedge clk);
    rst = 1'b0;
    cyc(5);
    chk("held_edge5", 32'(running), 32'd0);
    cyc(1);
    chk("held_edge6", 32'(running), 32'd1);
    btn_start = 1'b0;
    cyc(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/bcd_stopwatch4.md
# bcd_stopwatch4

Four-digit BCD stopwatch/counter that generates the D3..D0 digit values consumed by the `four` dynamic-display scanner. Two raw push-buttons (start/stop, clear) are synchronised and debounced. A prescaler divides `clk` into a count tick, and a ripple-carry BCD chain counts 0000–9999 with wrap-around. Outputs are registered and connect directly to the scanner's D0..D3 inputs.

## Interface
- `CLK_DIV`, default 50_000_000 — `clk` cycles per count tick; ≥2.
- `DEBOUNCE_CYCLES`, default 1_000_000 — cycles a synchronised button must be stable to be accepted; ≥1.
- `clk`  in  1 — single system clock.
- `rst`  in  1 — reset, asynchronous, active-high; clears all state.
- `btn_start`  in  1 — raw start/stop button, active-high, asynchronous to `clk`.
- `btn_clr`  in  1 — raw clear button, active-high, asynchronous to `clk`.
- `D0`  out  4 — BCD units digit.
- `D1`  out  4 — BCD tens digit.
- `D2`  out  4 — BCD hundreds digit.
- `D3`  out  4 — BCD thousands digit.
- `running`  out  1 — 1 while in RUN.
- `ovf`  out  1 — one-cycle pulse on the 9999→0000 wrap.

## Operation
- **Reset values:** D0–D3 = 0, `running` = 0, `ovf` = 0. Prescaler = 0, state = STOP, debouncers at level 0 with counters at 0.
- **Button path, per button:**
  - 2-FF synchroniser.
  - Debounce counter: cleared when the synchronised value equals the debounced level, otherwise incremented. When it reaches DEBOUNCE_CYCLES−1 and the value still differs, the level flips on the next edge and the counter clears.
  - Press pulse = level & ~level_d, where level_d is a one-cycle delayed copy of the level. The pulse is exactly one cycle; releases produce no pulse.
- **FSM states:** STOP and RUN.
  - `start_pulse` toggles STOP↔RUN.
  - `clr_pulse` forces STOP, zeroes the digits and zeroes the prescaler.
  - When both pulses occur in the same cycle, clear wins: the result is STOP with zeros.
- **Prescaler:** counts 0..CLK_DIV−1 only in RUN. `tick` is asserted when the prescaler equals CLK_DIV−1 in RUN; the prescaler then wraps to 0. In STOP the prescaler holds its value, so a pause/resume keeps the sub-tick phase.
- **BCD chain on tick:**
  - D0 += 1. If D0 was 9, D0 → 0 and the carry passes into D1; D2 and D3 follow the same rule.
  - All four digits update on the same edge.
  - 9999 → 0000 with `ovf` = 1 for that cycle only. Counting continues in RUN after the wrap.
- Digits never leave the 0–9 range. No input can load other values.

## Timing
- **Button latency:** a raw press held steady is accepted as follows.
  - Synchronised output: changes 2 edges after the raw press.
  - Debounced level: rises DEBOUNCE_CYCLES edges after that.
  - Press pulse: high in the following cycle.
  - Effect: `running` and the digit clear take effect on the edge that ends the pulse cycle.
- **First increment:** starting from prescaler 0, D0 becomes 1 exactly CLK_DIV edges after `running` rises.
- **Output timing:** `running` and `ovf` are registered and change on the same edge as the state and digits.
- **Async reset mid-run:** all outputs go to their reset values immediately. After release, the block restarts in STOP, and a button still held must first be debounced again before it is accepted.
- **Tick vs. stop/clear in the same cycle:**
  - `tick` and `start_pulse` (RUN→STOP): the tick increment is applied, then the block stops.
  - `tick` and `clr_pulse`: clear wins, digits = 0 and `ovf` = 0.

## Structure
- Package `stopwatch_pkg` holds:
  - `DIGIT_W = 4`
  - `DIGIT_MAX = 4'd9`
  - an enum `sw_state_t {STOP, RUN}`
- Sub-module `btn_debounce` (parameter DEBOUNCE_CYCLES; ports `clk`, `rst`, `btn_raw`, `press`) contains the synchroniser, debounce counter and edge detector. It is instantiated twice.
- The top level contains the FSM, the prescaler and the BCD chain.

## Test plan
All benches use CLK_DIV=4 and DEBOUNCE_CYCLES=3.
1. **Reset:** assert `rst` with buttons idle → D3..D0 = 0000, `running`=0, `ovf`=0. Deassert; idle 20 cycles → outputs unchanged.
2. **Start and count:** hold `btn_start` for 10 cycles → `running`=1 exactly 6 edges after the raw rise. After 48 further cycles → D1=1, D0=2, D2=D3=0.
3. **Bounce rejection:** pulse `btn_start` high for 2 cycles, low for 2, high for 2 → `running` stays 0. Then hold for 5 cycles → `running`=1.
4. **Pause/resume:** stop 2 cycles into a prescaler period, wait 20 cycles, then restart → the count is frozen while stopped. The next increment comes 2 cycles after `running` rises, showing the prescaler phase was preserved.
5. **Wrap:** run 40000 cycles from 0000 → `ovf` is high for exactly one cycle, coincident with digits 9999→0000; the count continues to 0001.
6. **Clear precedence and reset mid-run:**
   - Raw presses of both buttons aligned so their pulses coincide → `running`=0, digits 0000.
   - Assert `rst` mid-count at D0=3 → immediate all-zero outputs.
